// File: rtl/clint.sv
// clint: core-local interruptor with msip/mtimecmp/mtime registers and a two-state request/ack handshake.
module clint #(
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int          PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic        req_write,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_ok,
  output logic [63:0] resp_data,
  input  logic        ext_irq,
  output logic        trint,
  output logic        swint,
  output logic        exint
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic {IDLE, RESP} state_t;
  state_t      r_state, w_next;
  logic [PW-1:0] r_pre;
  logic [63:0] r_mtime, r_mtimecmp, r_rdata;
  logic        r_msip, r_trint, r_swint, r_exint;
  logic        w_acc, w_sel_msip, w_sel_cmp, w_sel_time, w_wrap;
  logic [63:0] w_mask, w_rd, w_time_wr, w_cmp_wr;
  always_comb begin
    w_acc      = r_state == IDLE && req_valid;
    w_next     = w_acc ? RESP : IDLE;
    w_sel_msip = req_addr == BASE;
    w_sel_cmp  = req_addr == BASE + 64'h4000;
    w_sel_time = req_addr == BASE + 64'hBFF8;
    w_rd       = w_sel_msip ? {63'b0, r_msip} : w_sel_cmp ? r_mtimecmp : w_sel_time ? r_mtime : 64'b0;
    for (int i = 0; i < 8; i++) w_mask[8*i+:8] = {8{req_strobe[i]}};
    w_time_wr  = (r_mtime & ~w_mask) | (req_data & w_mask);
    w_cmp_wr   = (r_mtimecmp & ~w_mask) | (req_data & w_mask);
    w_wrap     = r_pre == PW'(PRESCALE - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pre      <= '0;
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_msip     <= 1'b0;
      r_rdata    <= '0;
      r_trint    <= 1'b0;
      r_swint    <= 1'b0;
      r_exint    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) r_rdata <= w_rd;
      // an mtime write wins over the tick and restarts the prescaler
      if (w_acc && req_write && w_sel_time) begin
        r_mtime <= w_time_wr;
        r_pre   <= '0;
      end else begin
        r_mtime <= w_wrap ? r_mtime + 64'd1 : r_mtime;
        r_pre   <= w_wrap ? '0 : r_pre + 1'b1;
      end
      if (w_acc && req_write && w_sel_cmp) r_mtimecmp <= w_cmp_wr;
      if (w_acc && req_write && w_sel_msip && req_strobe[0]) r_msip <= req_data[0];
      r_trint <= r_mtime >= r_mtimecmp;
      r_swint <= r_msip;
      r_exint <= ext_irq;
    end
  end
  assign resp_ok   = r_state == RESP;
  assign resp_data = resp_ok ? r_rdata : 64'b0;
  assign trint     = r_trint;
  assign swint     = r_swint;
  assign exint     = r_exint;
endmodule
